// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states
// and the divide iteration count.
package hilo_pkg;

    localparam int DIV_CYCLES = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DIV_FIX = 2'd2
    } divState_e;

endpackage

// File: rtl/hilo_div_core.sv
// Unsigned restoring divider: one quotient bit per step, W steps per divide.
module hilo_div_core #(
    parameter int W = 32
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         lastStep
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  rem, quo, dvs;
    logic [CW-1:0] cnt;
    logic [W:0]    shifted, diff;

    // rem < divisor holds throughout, so diff[W] is a clean borrow flag
    assign shifted = {rem, quo[W-1]};
    assign diff    = shifted - {1'b0, dvs};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
            cnt <= CW'(W - 1);
        end else if (step) begin
            rem <= diff[W] ? shifted[W-1:0] : diff[W-1:0];
            quo <= {quo[W-2:0], ~diff[W]};
            if (cnt != '0) cnt <= cnt - CW'(1);
        end
    end

    assign quotient  = quo;
    assign remainder = rem;
    assign lastStep  = (cnt == '0);

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Execute-stage HI/LO unit: single-cycle MULT/MULTU/MTHI/MTLO, 33-cycle DIV/DIVU.
// Define HILO_MADD_EN to add the MADD/MSUB accumulate path.
module hilo_muldiv_unit #(
    parameter int DIV_CYCLES = hilo_pkg::DIV_CYCLES
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Done
);
    import hilo_pkg::*;

    divState_e state, nextState;
    logic      load, step, lastStep;
    logic      negQ, negR, divZero;

    logic        signedDiv;
    logic [32:0] aExt, bExt, aMag, bMag;
    logic        unusedMagBits;
    logic [31:0] quotient, remainder, qFix, rFix;

    logic signed [63:0] prodS;
    logic        [63:0] prodU;

    assign signedDiv = (Op == OP_DIV);
    assign aExt = signedDiv ? {A[31], A} : {1'b0, A};
    assign bExt = signedDiv ? {B[31], B} : {1'b0, B};
    // 33-bit magnitude keeps -2^31 representable as +2^31
    assign aMag = aExt[32] ? -aExt : aExt;
    assign bMag = bExt[32] ? -bExt : bExt;
    assign unusedMagBits = aMag[32] ^ bMag[32];

    assign prodS = $signed(A) * $signed(B);
    assign prodU = {32'd0, A} * {32'd0, B};

    hilo_div_core #(.W(DIV_CYCLES)) uDivCore (
        .Clk      (Clk),
        .Rst      (Rst),
        .load     (load),
        .step     (step),
        .dividend (aMag[31:0]),
        .divisor  (bMag[31:0]),
        .quotient (quotient),
        .remainder(remainder),
        .lastStep (lastStep)
    );

    assign qFix = divZero ? 32'hFFFF_FFFF : (negQ ? -quotient : quotient);
    assign rFix = negR ? -remainder : remainder;

`ifdef HILO_MADD_EN
    logic [63:0] accSum;
    assign accSum = (Op == OP_MSUB) ? ({HI, LO} - prodS) : ({HI, LO} + prodS);
`endif

    always_comb begin
        nextState = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (Start && (Op == OP_DIV || Op == OP_DIVU)) begin
                    load      = 1'b1;
                    nextState = DIV_RUN;
                end
            end
            DIV_RUN: begin
                step = 1'b1;
                if (lastStep) nextState = DIV_FIX;
            end
            DIV_FIX: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            divZero <= 1'b0;
        end else begin
            state <= nextState;
            Busy  <= (nextState != IDLE);
            Done  <= (state == DIV_FIX);
            if (load) begin
                negQ    <= aExt[32] ^ bExt[32];
                negR    <= aExt[32];
                divZero <= (B == 32'd0);
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            HI <= '0;
            LO <= '0;
        end else if (state == DIV_FIX) begin
            HI <= rFix;
            LO <= qFix;
        end else if (state == IDLE && Start) begin
            case (Op)
                OP_MULT:  {HI, LO} <= prodS;
                OP_MULTU: {HI, LO} <= prodU;
                OP_MTHI:  HI <= A;
                OP_MTLO:  LO <= A;
`ifdef HILO_MADD_EN
                OP_MADD,
                OP_MSUB:  {HI, LO} <= accSum;
`endif
                default: ;
            endcase
        end
    end

endmodule
